cam_capture_ctrl: RTL and testbench
===================================

// Module: cam_capture_ctrl
// PURPOSE
// Parametrised OV7670 capture engine; next generation of cam_read. Runs in the pixel-clock
// domain and assembles RGB565 byte pairs into pixels. Converts each pixel to a selectable
// output format and decimates by 1/2/4. Writes pixels linearly into buffer_ram_dp, with a
// single-shot/continuous capture handshake and per-frame status.
// PARAMETERS
// AW        15     memory address width
// DW        8      memory data width; formatted 16-bit pixel truncated to DW LSBs
// MAX_PX    19200  pixels accepted per frame (<= 2**AW); further pixels dropped
// PORTS
// clk          in   1   CAM_pclk; all logic on rising edge
// rst          in   1   asynchronous, active-low reset
// vsync        in   1   camera VSYNC (high = vertical blanking)
// href         in   1   camera HREF (high = valid line bytes)
// px_data      in   8   camera data byte
// capture_req  in   1   1-cycle pulse: arm capture of next frame
// cont         in   1   1 = continuous capture while held high
// mode         in   2   00 RGB332, 01 RGB444, 10 GRAY8, 11 RGB565
// decim        in   2   00 /1, 01 /2, 10 /4 (cols and lines), 11 treated as /4
// mem_px_addr  out  AW  write address
// mem_px_data  out  DW  write data
// px_wr        out  1   write strobe, 1 cycle per pixel
// busy         out  1   high in WAIT_VS and CAPTURE
// frame_done   out  1   1-cycle pulse at end of captured frame
// overflow     out  1   pixels dropped due to MAX_PX in last/current frame
// px_count     out  AW+1 pixels written in last completed frame
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE. All outputs 0. All counters 0. Byte phase 0.
// - vs_fall = vsync 1->0 (frame start); vs_rise = vsync 0->1 (frame end).
// - Both edges are detected from a registered copy of vsync.
// - FSM IDLE: capture_req=1 -> WAIT_VS.
// - FSM WAIT_VS: vs_fall -> CAPTURE. Latch mode/decim; zero addr, col, line and overflow.
// - FSM CAPTURE: vs_rise -> frame_done=1 for 1 cycle and px_count <= pixels written.
//   Then -> CAPTURE if cont=1 and the next vs_fall is waited on (WAIT_VS); else -> IDLE.
// - capture_req is ignored outside IDLE. cont is sampled only at vs_rise.
// - mode/decim changes mid-frame are ignored until the next frame start.
// - Byte pairing: only in CAPTURE with href=1. Phase 0 stores byte as hi; phase 1 forms
//   pix={hi,px_data} = R5 G6 B5. Phase toggles each href cycle.
// - Phase resets to 0 while href=0; an odd trailing byte is discarded.
// - Decimation: col counts pixels in line and resets on href rise.
// - Decimation: line increments on href fall.
// - Pixel kept iff col[k-1:0]==0 and line[k-1:0]==0, where k = 0/1/2 for /1 /2 /4.
// - Format (R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}):
//   RGB332 = {R5[4:2],G6[5:3],B5[4:3]}.
//   RGB444 = {R5[4:1],G6[5:2],B5[4:1]}.
//   GRAY8  = (R8+2*G8+B8)>>2, from a 10-bit sum.
//   RGB565 = pix.
//   All formats are zero-extended to 16 bits, then mem_px_data = fmt[DW-1:0].
// - Latency: on the edge sampling phase-1 byte of a kept pixel, register mem_px_data and
//   mem_px_addr=addr, and px_wr=1 for the following cycle. addr increments on that edge.
// - addr == MAX_PX: no px_wr and no increment; overflow set (sticky until next frame start).
// - px_count saturates at MAX_PX.
// - vs_rise mid-line ends the frame; the partial pixel is discarded.
// - href=1 outside CAPTURE produces no writes.
// - Simultaneous vs_rise and a completing pixel: the pixel is written and counted, then done.
// - rst low mid-frame aborts immediately to IDLE; no frame_done.
// TESTING
// - Reset, capture_req, vs_fall, 2 lines x 4 px (0xF800 RGB565), mode=11, decim=00
//   -> 8 writes, addr 0..7, data 0x00 (DW=8 truncation of 0xF800).
//   -> frame_done 1 cycle after vs_rise; px_count=8; state IDLE.
// - DW=8, mode=00, pixel bytes 0xFF,0xE0 (R=31,G=63,B=0) -> mem_px_data=0xFC.
//   - Same pixel, mode=10 -> (255+510+0)>>2 = 0xBF.
// - decim=01, 4 lines x 8 px -> writes only for lines 0,2 and cols 0,2,4,6.
//   -> 8 writes, addr 0..7, px_count=8.
// - MAX_PX=4, 6 px frame -> 4 writes; overflow=1; px_count=4.
//   - Next frame, 2 px -> overflow cleared at vs_fall.
// - cont=1, 3 frames -> 3 frame_done pulses, busy stays 1.
//   - Drop cont during frame 3 -> IDLE after its vs_rise.
//   - capture_req while busy -> no effect.
// - Odd byte count on a line (5 bytes) -> 2 writes; phase 0 at next line start.
//   - rst low mid-line -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cam_capture_ctrl.sv
// OV7670 capture engine: pairs RGB565 bytes into pixels, reformats, decimates and
// writes them linearly into the frame buffer with single-shot/continuous framing.
module cam_capture_ctrl #(
  parameter int AW     = 15,
  parameter int DW     = 8,
  parameter int MAX_PX = 19200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  input  logic          capture_req,
  input  logic          cont,
  input  logic [1:0]    mode,
  input  logic [1:0]    decim,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          busy,
  output logic          frame_done,
  output logic          overflow,
  output logic [AW:0]   px_count
);
  localparam int FW = (DW > 16) ? DW : 16;
  localparam logic [AW:0] MAX_V = (AW+1)'(MAX_PX);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_CAPTURE} state_e;

  state_e        state_q, state_d;
  logic          vs_q, vs_d, href_q, href_d, phase_q, phase_d;
  logic [7:0]    hi_q, hi_d;
  logic [1:0]    mode_q, mode_d, decim_q, decim_d;
  logic [AW:0]   addr_q, addr_d, cnt_q, cnt_d;
  logic [AW-1:0] col_q, col_d, line_q, line_d, wa_q, wa_d;
  logic [DW-1:0] wd_q, wd_d;
  logic          wr_q, wr_d, busy_q, busy_d, fd_q, fd_d, ovf_q, ovf_d;

  logic          vs_fall, vs_rise, h_rise, h_fall, pix_done, keep, room;
  logic [1:0]    msk;
  logic [15:0]   pix;
  logic [4:0]    r5, b5;
  logic [5:0]    g6;
  logic [7:0]    r8, g8, b8;
  logic [9:0]    gsum;
  logic [FW-1:0] fmt;

  assign vs_fall  = vs_q & ~vsync;
  assign vs_rise  = ~vs_q & vsync;
  assign h_rise   = href & ~href_q;
  assign h_fall   = ~href & href_q;
  assign pix_done = (state_q == S_CAPTURE) & href & phase_q;
  assign room     = (addr_q < MAX_V);

  always_comb begin
    case (decim_q)
      2'b00:   msk = 2'b00;
      2'b01:   msk = 2'b01;
      default: msk = 2'b11;
    endcase
  end

  // Keep only pixels on the decimation grid of both column and line.
  assign keep = ((col_q[1:0] & msk) == 2'b00) && ((line_q[1:0] & msk) == 2'b00);

  always_comb begin
    pix  = {hi_q, px_data};
    r5   = pix[15:11];
    g6   = pix[10:5];
    b5   = pix[4:0];
    r8   = {r5, r5[4:2]};
    g8   = {g6, g6[5:4]};
    b8   = {b5, b5[4:2]};
    gsum = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};
    fmt  = '0;
    case (mode_q)
      2'b00:   fmt[7:0]  = {r5[4:2], g6[5:3], b5[4:3]};
      2'b01:   fmt[11:0] = {r5[4:1], g6[5:2], b5[4:1]};
      2'b10:   fmt[7:0]  = 8'(gsum >> 2);
      default: fmt[15:0] = pix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    vs_d    = vsync;
    href_d  = href;
    phase_d = 1'b0;
    hi_d    = hi_q;
    mode_d  = mode_q;
    decim_d = decim_q;
    addr_d  = addr_q;
    col_d   = col_q;
    line_d  = line_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    wr_d    = 1'b0;
    fd_d    = 1'b0;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (capture_req) state_d = S_WAIT_VS;
      S_WAIT_VS: begin
        if (vs_fall) begin
          state_d = S_CAPTURE;
          mode_d  = mode;
          decim_d = decim;
          addr_d  = '0;
          col_d   = '0;
          line_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (href) begin
          phase_d = ~phase_q;
          if (!phase_q) hi_d = px_data;
        end
        if (h_rise)        col_d = '0;
        else if (pix_done) col_d = col_q + AW'(1);
        if (h_fall) line_d = line_q + AW'(1);
        if (pix_done && keep) begin
          if (room) begin
            wa_d   = addr_q[AW-1:0];
            wd_d   = DW'(fmt);
            wr_d   = 1'b1;
            addr_d = addr_q + (AW+1)'(1);
          end else begin
            ovf_d  = 1'b1;
          end
        end
        // A pixel completing on the vs_rise edge is still counted via addr_d.
        if (vs_rise) begin
          fd_d    = 1'b1;
          cnt_d   = addr_d;
          phase_d = 1'b0;
          state_d = cont ? S_WAIT_VS : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      vs_q    <= 1'b0;
      href_q  <= 1'b0;
      phase_q <= 1'b0;
      hi_q    <= '0;
      mode_q  <= '0;
      decim_q <= '0;
      addr_q  <= '0;
      col_q   <= '0;
      line_q  <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= vs_d;
      href_q  <= href_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      mode_q  <= mode_d;
      decim_q <= decim_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      line_q  <= line_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_px_addr = wa_q;
  assign mem_px_data = wd_q;
  assign px_wr       = wr_q;
  assign busy        = busy_q;
  assign frame_done  = fd_q;
  assign overflow    = ovf_q;
  assign px_count    = cnt_q;
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench for cam_capture_ctrl: a full-size instance and a MAX_PX=4 instance share stimulus;
// writes are scoreboarded against queues filled while bytes are driven.
module tb_cam_capture_ctrl;
  localparam int AW = 15;
  localparam int DW = 8;
  localparam int BIG_MAX = 19200;
  localparam int SMALL_MAX = 4;

  logic clk = 1'b0;
  logic rst, vsync, href, capture_req, cont;
  logic [7:0] px_data;
  logic [1:0] mode, decim;
  logic [AW-1:0] b_addr, s_addr;
  logic [DW-1:0] b_data, s_data;
  logic b_wr, s_wr, b_busy, s_busy, b_fd, s_fd, b_ovf, s_ovf;
  logic [AW:0] b_cnt, s_cnt;

  always #5 clk = ~clk;

  cam_capture_ctrl #(.AW(AW), .DW(DW), .MAX_PX(BIG_MAX)) u_dut (
    .clk(clk), .rst(rst), .vsync(vsync), .href(href), .px_data(px_data),
    .capture_req(capture_req), .cont(cont), .mode(mode), .decim(decim),
    .mem_px_addr(b_addr), .mem_px_data(b_data), .px_wr(b_wr), .busy(b_busy),
    .frame_done(b_fd), .overflow(b_ovf), .px_count(b_cnt));

  cam_capture_ctrl #(.AW(AW), .DW(DW), .MAX_PX(SMALL_MAX)) u_small (
    .clk(clk), .rst(rst), .vsync(vsync), .href(href), .px_data(px_data),
    .capture_req(capture_req), .cont(cont), .mode(mode), .decim(decim),
    .mem_px_addr(s_addr), .mem_px_data(s_data), .px_wr(s_wr), .busy(s_busy),
    .frame_done(s_fd), .overflow(s_ovf), .px_count(s_cnt));

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [1:0] mode; logic [15:0] pix; logic [7:0] exp; } vec_t;

  wr_t  qb[$], qs[$];
  wr_t  mb, ms;
  vec_t tbl[12];
  int   n_cmp = 0, n_err = 0, fd_cnt = 0;
  int   ea, es;
  logic eovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input logic [31:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got 0x%0h expected no write", nm, act);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (b_fd) fd_cnt++;
      if (b_wr) begin
        if (qb.size() == 0) flag("big_unexpected_wr", 32'({b_addr, b_data}));
        else begin
          mb = qb.pop_front();
          chk("big_wr", 32'({b_addr, b_data}), 32'({mb.addr, mb.data}));
        end
      end
      if (s_wr) begin
        if (qs.size() == 0) flag("small_unexpected_wr", 32'({s_addr, s_data}));
        else begin
          ms = qs.pop_front();
          chk("small_wr", 32'({s_addr, s_data}), 32'({ms.addr, ms.data}));
        end
      end
    end
  end

  function automatic logic [15:0] pix_of(input int l, input int c);
    logic [7:0] h, lo;
    h  = 8'(l * 29 + c * 13 + 7);
    lo = 8'((c * 53) ^ (l * 17 + 3));
    return {h, lo};
  endfunction

  function automatic logic [7:0] fmt_model(input logic [1:0] m, input logic [15:0] p);
    logic [4:0] r, b;
    logic [5:0] g;
    logic [7:0] r8, g8, b8;
    logic [15:0] f;
    int s;
    r = p[15:11]; g = p[10:5]; b = p[4:0];
    r8 = {r, r[4:2]}; g8 = {g, g[5:4]}; b8 = {b, b[4:2]};
    s = int'(r8) + 2 * int'(g8) + int'(b8);
    case (m)
      2'd0:    f = {8'h00, r[4:2], g[5:3], b[4:3]};
      2'd1:    f = {4'h0, r[4:1], g[5:2], b[4:1]};
      2'd2:    f = 16'(s >> 2);
      default: f = p;
    endcase
    return f[7:0];
  endfunction

  task automatic push(input logic [7:0] d);
    wr_t e;
    if (ea < BIG_MAX) begin
      e.addr = AW'(ea); e.data = d; qb.push_back(e); ea++;
    end
    if (es < SMALL_MAX) begin
      e.addr = AW'(es); e.data = d; qs.push_back(e); es++;
    end else eovf = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: optional arm pulse, vs_fall, nl lines of nb bytes, vs_rise, then checks.
  task automatic frame(input int nl, input int nb, input bit arm, input bit live,
                       input bit ov, input logic [15:0] opix, input logic [7:0] oexp,
                       input bit cont_mid, input bit req_mid);
    logic [15:0] p;
    int c, msk, fd0;
    fd0 = fd_cnt;
    if (arm) begin capture_req = 1'b1; tick(); capture_req = 1'b0; end
    tick(); tick();
    vsync = 1'b0;
    tick();
    ea = 0; es = 0; eovf = 1'b0;
    msk = (decim == 2'd0) ? 0 : (decim == 2'd1) ? 1 : 3;
    @(negedge clk);
    if (live) chk("ovf_clear_at_vs_fall", 32'(s_ovf), 32'(0));
    cont = cont_mid;
    tick();
    for (int l = 0; l < nl; l++) begin
      for (int b = 0; b < nb; b++) begin
        href = 1'b1;
        c = b / 2;
        p = ov ? opix : pix_of(l, c);
        px_data = (b % 2 == 1) ? p[7:0] : p[15:8];
        if (live && (b % 2 == 1) && ((c & msk) == 0) && ((l & msk) == 0))
          push(ov ? oexp : fmt_model(mode, p));
        if (req_mid && l == 0 && b == 0) capture_req = 1'b1;
        tick();
        capture_req = 1'b0;
      end
      href = 1'b0;
      tick(); tick(); tick();
    end
    vsync = 1'b1;
    tick();
    @(negedge clk);
    chk("frame_done_pulse", 32'(b_fd), 32'(live));
    if (live) begin
      chk("px_count", 32'(b_cnt), 32'(ea));
      chk("small_px_count", 32'(s_cnt), 32'(es));
      chk("small_overflow", 32'(s_ovf), 32'(eovf));
      chk("busy_after_frame", 32'(b_busy), 32'(cont_mid));
    end
    tick();
    @(negedge clk);
    chk("frame_done_low", 32'(b_fd), 32'(0));
    chk("big_queue_drained", 32'(qb.size()), 32'(0));
    chk("small_queue_drained", 32'(qs.size()), 32'(0));
    if (!live) chk("no_frame_done_when_idle", 32'(fd_cnt), 32'(fd0));
    tick();
  endtask

  initial begin
    tbl[0]  = '{2'd0, 16'hFFE0, 8'hFC};
    tbl[1]  = '{2'd2, 16'hFFE0, 8'hBF};
    tbl[2]  = '{2'd3, 16'hF800, 8'h00};
    tbl[3]  = '{2'd3, 16'h1234, 8'h34};
    tbl[4]  = '{2'd1, 16'hFFFF, 8'hFF};
    tbl[5]  = '{2'd1, 16'h8410, 8'h88};
    tbl[6]  = '{2'd0, 16'h8410, 8'h92};
    tbl[7]  = '{2'd2, 16'hFFFF, 8'hFF};
    tbl[8]  = '{2'd2, 16'h8410, 8'h83};
    tbl[9]  = '{2'd0, 16'h001F, 8'h03};
    tbl[10] = '{2'd2, 16'h001F, 8'h3F};
    tbl[11] = '{2'd1, 16'h07E0, 8'hF0};

    rst = 1'b1; vsync = 1'b1; href = 1'b0; px_data = '0;
    capture_req = 1'b0; cont = 1'b0; mode = 2'd3; decim = 2'd0;
    #1 rst = 1'b0;
    #1;
    chk("reset_outputs", 32'({b_addr, b_data, b_wr, b_busy, b_fd, b_ovf, b_cnt}), 32'(0));
    chk("reset_small_outputs", 32'({s_wr, s_busy, s_fd, s_ovf, s_cnt}), 32'(0));
    tick(); tick();
    rst = 1'b1;
    tick();

    // 2 lines x 4 px of 0xF800 in RGB565: data truncates to 0x00
    mode = 2'd3; decim = 2'd0;
    frame(2, 8, 1, 1, 1, 16'hF800, 8'h00, 0, 0);

    for (int i = 0; i < 12; i++) begin
      mode = tbl[i].mode;
      frame(1, 2, 1, 1, 1, tbl[i].pix, tbl[i].exp, 0, 0);
    end

    // decimation /2 then /4 (decim=11)
    mode = 2'd3; decim = 2'd1;
    frame(4, 16, 1, 1, 0, 16'h0, 8'h0, 0, 0);
    mode = 2'd2; decim = 2'd3;
    frame(8, 16, 1, 1, 0, 16'h0, 8'h0, 0, 0);

    // 6 px frame overflows the small instance, next 2 px frame clears it
    mode = 2'd0; decim = 2'd0;
    frame(1, 12, 1, 1, 0, 16'h0, 8'h0, 0, 0);
    frame(1, 4, 1, 1, 0, 16'h0, 8'h0, 0, 0);

    // continuous: three frames, stray capture_req while busy, cont dropped in frame 3
    begin
      int fd_start;
      fd_start = fd_cnt;
      mode = 2'd1; cont = 1'b1;
      frame(2, 6, 1, 1, 0, 16'h0, 8'h0, 1, 0);
      frame(2, 6, 0, 1, 0, 16'h0, 8'h0, 1, 1);
      frame(2, 6, 0, 1, 0, 16'h0, 8'h0, 0, 1);
      chk("cont_frame_done_count", 32'(fd_cnt - fd_start), 32'(3));
      chk("idle_after_cont_drop", 32'(b_busy), 32'(0));
    end

    // odd trailing byte: 5 bytes per line yields 2 pixels per line
    mode = 2'd3; decim = 2'd0;
    frame(2, 5, 1, 1, 0, 16'h0, 8'h0, 0, 0);

    // async reset mid-line
    capture_req = 1'b1; tick(); capture_req = 1'b0; tick();
    vsync = 1'b0; tick(); tick();
    ea = 0; es = 0; eovf = 1'b0;
    href = 1'b1; px_data = 8'hAB; tick();
    px_data = 8'hCD; push(fmt_model(2'd3, 16'hABCD)); tick();
    px_data = 8'h11; tick();
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({b_addr, b_data, b_wr, b_busy, b_fd, b_ovf, b_cnt}), 32'(0));
    chk("async_reset_small_busy", 32'(s_busy), 32'(0));
    #2 rst = 1'b1;
    href = 1'b0; vsync = 1'b1;
    tick(); tick();
    chk("reset_queue_drained", 32'(qb.size()), 32'(0));

    // href activity while IDLE must not write
    frame(2, 4, 0, 0, 0, 16'h0, 8'h0, 0, 0);
    chk("idle_busy", 32'(b_busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
